seg7_count_display: RTL and testbench

// - Display side of the LED counter path: takes the 8-bit counter value and shows it as

---
 rtl/seg7_count_display_pkg.sv | 53 +++++
 rtl/seg7_count_display_if.sv | 14 +
 rtl/seg7_count_display_bin2bcd_seq.sv | 94 +++++++++
 rtl/seg7_count_display.sv | 87 ++++++++
 tb/tb_seg7_count_display.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_count_display_pkg.sv
// Shared types, constants and helpers for the counter 7-segment display path.
package seg7_count_display_pkg;

  localparam int unsigned VAL_W = 8;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DIG_W = 2;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [DIG_W-1:0] DIG_ONES     = 2'd0;
  localparam logic [DIG_W-1:0] DIG_TENS     = 2'd1;
  localparam logic [DIG_W-1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [DIG_W-1:0] DIG_BLANK    = 2'd3;

  typedef struct packed {
    logic [NIB_W-1:0] hundreds;
    logic [NIB_W-1:0] tens;
    logic [NIB_W-1:0] ones;
  } bcd3_t;

  // Active-high {g,f,e,d,c,b,a}; anything outside 0..9 goes dark.
  function automatic logic [SEG_W-1:0] seg_pattern(input logic [NIB_W-1:0] digit);
    logic [SEG_W-1:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // Double-dabble correction applied to a nibble before each shift.
  function automatic logic [NIB_W-1:0] add3(input logic [NIB_W-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_count_display_if.sv
// Value input and display/status outputs of the 7-segment display block.
interface seg7_count_display_if;
  import seg7_count_display_pkg::*;

  logic [VAL_W-1:0] val;
  logic [AN_W-1:0]  an;
  logic [SEG_W-1:0] seg;
  logic             dp;
  logic             busy;

  modport master (output val, input an, seg, dp, busy);
  modport slave  (input val, output an, seg, dp, busy);

endinterface

// File: rtl/seg7_count_display_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, one bit per clock, atomic result update.
module bin2bcd_seq
  import seg7_count_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] val,
  output bcd3_t            digits,
  output logic             busy
);

  conv_state_e      state;
  conv_state_e      state_next;
  logic [VAL_W-1:0] shift_reg;
  logic [VAL_W-1:0] lat_val;
  logic [VAL_W-1:0] last_val;
  logic [BCD_W-1:0] bcd_acc;
  logic [BCD_W-1:0] bcd_adj_c;
  logic [CNT_W-1:0] bit_cnt;
  logic             force_conv;
  logic             start_c;
  logic             load_c;
  logic             shift_c;
  logic             commit_c;

  assign start_c   = force_conv || (val != last_val);
  assign bcd_adj_c = {add3(bcd_acc[11:8]), add3(bcd_acc[7:4]), add3(bcd_acc[3:0])};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_c) state_next = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == CNT_W'(7)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath strobes
  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    commit_c = 1'b0;
    case (state)
      ST_IDLE:  load_c   = start_c;
      ST_SHIFT: shift_c  = 1'b1;
      ST_DONE:  commit_c = 1'b1;
      default:  ;
    endcase
  end

  // Conversion datapath; result only leaves through the single commit write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      lat_val    <= '0;
      last_val   <= '0;
      bcd_acc    <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      force_conv <= 1'b1;
      digits     <= '0;
    end else begin
      if (load_c) begin
        shift_reg <= val;
        lat_val   <= val;
        bcd_acc   <= '0;
        bit_cnt   <= '0;
        busy      <= 1'b1;
      end
      if (shift_c) begin
        {bcd_acc, shift_reg} <= {bcd_adj_c[BCD_W-2:0], shift_reg, 1'b0};
        bit_cnt              <= bit_cnt + CNT_W'(1);
      end
      if (commit_c) begin
        digits     <= bcd3_t'(bcd_acc);
        last_val   <= lat_val;
        force_conv <= 1'b0;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_count_display.sv
// Decimal display of an 8-bit value on a 4-digit multiplexed 7-segment display.
module seg7_count_display
  import seg7_count_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          AN_ACT   = 1'b0,
  parameter bit          SEG_ACT  = 1'b0
) (
  input logic                 CLK50MHz,
  input logic                 RST,
  seg7_count_display_if.slave io
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  bcd3_t             digits;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DIG_W-1:0]  digit_idx;
  logic [AN_W-1:0]   sel_an_c;
  logic [SEG_W-1:0]  sel_seg_c;
  logic              hundreds_on_c;
  logic              tens_on_c;

  bin2bcd_seq u_conv (
    .clk    (CLK50MHz),
    .rst_n  (RST),
    .val    (io.val),
    .digits (digits),
    .busy   (io.busy)
  );

  // Free-running slot timer and digit index
  always_ff @(posedge CLK50MHz or negedge RST) begin
    if (!RST) begin
      scan_cnt  <= '0;
      digit_idx <= DIG_ONES;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + DIG_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign hundreds_on_c = (digits.hundreds != '0);
  assign tens_on_c     = hundreds_on_c || (digits.tens != '0);

  // Digit mux with leading-zero blanking, active-high internally
  always_comb begin
    sel_an_c  = '0;
    sel_seg_c = '0;
    case (digit_idx)
      DIG_ONES: begin
        sel_an_c  = 4'b0001;
        sel_seg_c = seg_pattern(digits.ones);
      end
      DIG_TENS: begin
        if (tens_on_c) begin
          sel_an_c  = 4'b0010;
          sel_seg_c = seg_pattern(digits.tens);
        end
      end
      DIG_HUNDREDS: begin
        if (hundreds_on_c) begin
          sel_an_c  = 4'b0100;
          sel_seg_c = seg_pattern(digits.hundreds);
        end
      end
      DIG_BLANK: ;
      default: ;
    endcase
  end

  // Output registers with board polarity applied
  always_ff @(posedge CLK50MHz or negedge RST) begin
    if (!RST) begin
      io.an  <= {AN_W{~AN_ACT}};
      io.seg <= {SEG_W{~SEG_ACT}};
      io.dp  <= ~SEG_ACT;
    end else begin
      io.an  <= AN_ACT  ? sel_an_c  : ~sel_an_c;
      io.seg <= SEG_ACT ? sel_seg_c : ~sel_seg_c;
      io.dp  <= ~SEG_ACT;
    end
  end

endmodule

// File: tb/tb_seg7_count_display.sv
// Bench for seg7_count_display: arithmetic display model checked every cycle plus literal pins.
module tb_seg7_count_display;
  import seg7_count_display_pkg::*;

  localparam int unsigned SD = 4;
  localparam logic [6:0] FONT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg7_count_display_if io ();

  seg7_count_display #(.SCAN_DIV(SD), .AN_ACT(1'b0), .SEG_ACT(1'b0)) dut (
    .CLK50MHz (clk),
    .RST      (rst_n),
    .io       (io)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: edges since reset, shown value, and conversion in flight
  int n = 0;
  int disp = 0;
  int prev_disp = 0;
  int lat = 0;
  int last = 0;
  int cnt = 0;
  bit force_f = 1'b1;
  bit busy_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 0; disp <= 0; prev_disp <= 0; lat <= 0; last <= 0;
      cnt <= 0; force_f <= 1'b1; busy_m <= 1'b0;
    end else begin
      n <= n + 1;
      prev_disp <= disp;
      if (!busy_m) begin
        if (force_f || int'(io.val) != last) begin
          busy_m <= 1'b1;
          lat <= int'(io.val);
          cnt <= 9;
        end
      end else begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          busy_m <= 1'b0;
          disp <= lat;
          last <= lat;
          force_f <= 1'b0;
        end
      end
    end
  end

  function automatic void expect_out(output logic [3:0] an, output logic [6:0] seg);
    int slot;
    int v;
    an = 4'hF;
    seg = 7'h7F;
    if (n == 0) return;
    slot = ((n - 1) / SD) % 4;
    v = prev_disp;
    case (slot)
      0: begin an = 4'hE; seg = ~FONT[v % 10]; end
      1: if (v >= 10)  begin an = 4'hD; seg = ~FONT[(v / 10) % 10]; end
      2: if (v >= 100) begin an = 4'hB; seg = ~FONT[v / 100]; end
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [3:0] ea;
    logic [6:0] es;
    expect_out(ea, es);
    check("an_cycle", 32'(io.an), 32'(ea));
    check("seg_cycle", 32'(io.seg), 32'(es));
    check("dp_cycle", 32'(io.dp), 32'd1);
    check("busy_cycle", 32'(io.busy), 32'(busy_m));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input int s);
    for (int i = 0; i < 4 * SD + 2; i++) begin
      if (n >= 1 && ((n - 1) / SD) % 4 == s) return;
      tick();
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_slot: slot %0d never reached", s);
  endtask

  initial begin
    int bcnt;
    io.val = 8'd0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_an", 32'(io.an), 32'hF);
    check("rst_seg", 32'(io.seg), 32'h7F);
    check("rst_dp", 32'(io.dp), 32'h1);
    check("rst_busy", 32'(io.busy), 32'h0);
    rst_n = 1'b1;
    repeat (12) tick();
    check("init_busy", 32'(io.busy), 32'h0);
    check("init_model", disp, 0);

    // 255: busy length and digit patterns
    io.val = 8'd255;
    bcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (io.busy) bcnt++;
    end
    check("busy_len_255", bcnt, 9);
    check("model_255", disp, 255);
    wait_slot(0);
    check("ones_an_255", 32'(io.an), 32'hE);
    check("ones_seg_255", 32'(io.seg), 32'h12);
    wait_slot(1);
    check("tens_seg_255", 32'(io.seg), 32'h12);
    wait_slot(2);
    check("hund_an_255", 32'(io.an), 32'hB);
    check("hund_seg_255", 32'(io.seg), 32'h24);

    // 0: only the ones digit lights
    io.val = 8'd0;
    repeat (12 + 4 * SD) tick();
    wait_slot(1);
    check("tens_an_0", 32'(io.an), 32'hF);
    wait_slot(2);
    check("hund_an_0", 32'(io.an), 32'hF);
    wait_slot(0);
    check("ones_seg_0", 32'(io.seg), 32'h40);

    // 107: inner zero stays visible
    io.val = 8'd107;
    repeat (12) tick();
    wait_slot(1);
    check("tens_an_107", 32'(io.an), 32'hD);
    check("tens_seg_107", 32'(io.seg), 32'h40);
    wait_slot(2);
    check("hund_seg_107", 32'(io.seg), 32'h79);
    wait_slot(0);
    check("ones_seg_107", 32'(io.seg), 32'h78);

    // 34 then 200 two cycles into the conversion
    io.val = 8'd34;
    repeat (3) tick();
    io.val = 8'd200;
    repeat (7) tick();
    check("model_34", disp, 34);
    repeat (12) tick();
    check("model_200", disp, 200);
    wait_slot(2);
    check("hund_seg_200", 32'(io.seg), 32'h24);
    wait_slot(0);
    check("ones_seg_200", 32'(io.seg), 32'h40);

    // 99 with reset after five shifts
    io.val = 8'd99;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", 32'(io.busy), 32'h0);
    check("mid_rst_an", 32'(io.an), 32'hF);
    check("mid_rst_seg", 32'(io.seg), 32'h7F);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("model_99", disp, 99);
    wait_slot(0);
    check("ones_seg_99", 32'(io.seg), 32'h10);
    repeat (SD) tick();
    check("rotate_an_99", 32'(io.an), 32'hD);
    check("tens_seg_99", 32'(io.seg), 32'h10);
    repeat (SD) tick();
    check("hund_an_99", 32'(io.an), 32'hF);
    repeat (SD) tick();
    check("blank_an_99", 32'(io.an), 32'hF);
    repeat (SD) tick();
    check("wrap_an_99", 32'(io.an), 32'hE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
